// File: rtl/kernel_bram_pingpong_cu_if.sv
// kernel_bram_pingpong_cu_if: AXI4-Stream kernel input plus both kernel BRAM ports
//   slave  : control-unit view (consumes the stream, drives BRAM ports A and B)
//   master : environment view (drives the stream, observes the BRAM ports)
interface kernel_bram_pingpong_cu_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
);
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tlast;
   logic              s_axis_tready;
   logic              ena_ker_BRAM;
   logic              wea_ker_BRAM;
   logic [ADDR_W:0]   addra_ker_BRAM;
   logic [DATA_W-1:0] dina_ker_BRAM;
   logic              enb_ker_BRAM;
   logic [ADDR_W:0]   addrb_ker_BRAM;
   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      output s_axis_tready, ena_ker_BRAM, wea_ker_BRAM, addra_ker_BRAM, dina_ker_BRAM,
             enb_ker_BRAM, addrb_ker_BRAM
   );
   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast,
      input  s_axis_tready, ena_ker_BRAM, wea_ker_BRAM, addra_ker_BRAM, dina_ker_BRAM,
             enb_ker_BRAM, addrb_ker_BRAM
   );
endinterface

// File: rtl/kernel_bram_pingpong_cu.sv
// kernel_bram_pingpong_cu: ping-pong kernel BRAM control (stream writes one bank, reads step the other)
//   clk, Reset (async, active low)
//   load_BRAM_dina / update_BRAM_doutb / swap_bank : single-cycle command pulses
//   CHANNEL_SIZE : words per kernel set (1..2^ADDR_W), sampled when a load is accepted
//   bus          : AXI4-Stream slave input, BRAM port A (write) and port B (read)
//   last_loading_1ker, last_channel, load_busy, wbank_full, rbank_valid, tlast_err : status
module kernel_bram_pingpong_cu #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 9
) (
   input  logic                     clk,
   input  logic                     Reset,
   input  logic                     load_BRAM_dina,
   input  logic                     update_BRAM_doutb,
   input  logic                     swap_bank,
   input  logic [ADDR_W:0]          CHANNEL_SIZE,
   kernel_bram_pingpong_cu_if.slave bus,
   output logic                     last_loading_1ker,
   output logic                     last_channel,
   output logic                     load_busy,
   output logic                     wbank_full,
   output logic                     rbank_valid,
   output logic                     tlast_err
);
   typedef enum logic [1:0] {W_IDLE, W_LOAD, W_DONE} wstate_t;
   wstate_t           state, state_nx;
   logic              wsel;
   logic [ADDR_W-1:0] a_cnt, b_cnt;
   logic [ADDR_W:0]   wsize, rsize;
   logic              swap_acc, load_acc, hs, final_beat, b_wrap;
   always_ff @(posedge clk or negedge Reset)
      if (!Reset) state <= W_IDLE;
      else state <= state_nx;
   always_comb begin
      swap_acc   = swap_bank && state == W_IDLE && wbank_full;
      load_acc   = load_BRAM_dina && state == W_IDLE && !wbank_full && !swap_acc && CHANNEL_SIZE != '0;
      hs         = state == W_LOAD && bus.s_axis_tvalid;
      final_beat = hs && {1'b0, a_cnt} == wsize - 1'b1;
      b_wrap     = {1'b0, b_cnt} == rsize - 1'b1;
      state_nx   = state == W_IDLE ? (load_acc ? W_LOAD : W_IDLE) :
                   state == W_LOAD ? (final_beat ? W_DONE : W_LOAD) : W_IDLE;
   end
   always_ff @(posedge clk or negedge Reset)
      if (!Reset) begin
         wsel         <= 1'b0;
         a_cnt        <= '0;
         b_cnt        <= '0;
         wsize        <= '0;
         rsize        <= '0;
         wbank_full   <= 1'b0;
         rbank_valid  <= 1'b0;
         tlast_err    <= 1'b0;
         last_channel <= 1'b0;
      end else begin
         if (load_acc) begin
            wsize <= CHANNEL_SIZE;
            a_cnt <= '0;
         end else if (hs) a_cnt <= final_beat ? '0 : a_cnt + 1'b1;
         // tlast must coincide exactly with the counted final beat
         if (hs && bus.s_axis_tlast != final_beat) tlast_err <= 1'b1;
         // swap only happens in W_IDLE, so it never collides with a write beat
         if (swap_acc) begin
            wsel         <= ~wsel;
            rsize        <= wsize;
            b_cnt        <= '0;
            wbank_full   <= 1'b0;
            rbank_valid  <= 1'b1;
            last_channel <= 1'b0;
         end else begin
            if (final_beat) wbank_full <= 1'b1;
            last_channel <= update_BRAM_doutb && rbank_valid && b_wrap;
            if (update_BRAM_doutb && rbank_valid) b_cnt <= b_wrap ? '0 : b_cnt + 1'b1;
         end
      end
   assign bus.s_axis_tready  = state == W_LOAD;
   assign bus.ena_ker_BRAM   = state == W_LOAD;
   assign bus.wea_ker_BRAM   = hs;
   assign bus.addra_ker_BRAM = {wsel, a_cnt};
   assign bus.dina_ker_BRAM  = bus.s_axis_tdata;
   assign bus.enb_ker_BRAM   = rbank_valid;
   // port B is parked at 0 until a set has been swapped in, so every output idles at 0
   assign bus.addrb_ker_BRAM = rbank_valid ? {~wsel, b_cnt} : '0;
   assign last_loading_1ker  = final_beat;
   assign load_busy          = state != W_IDLE;
endmodule

// File: tb/tb_kernel_bram_pingpong_cu.sv
// tb_kernel_bram_pingpong_cu: directed + random check of the ping-pong kernel BRAM control unit
module tb_kernel_bram_pingpong_cu;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 1 << ADDR_W;
   typedef logic [ADDR_W:0] csz_t;
   logic clk = 1'b0;
   logic Reset = 1'b1;
   logic load_BRAM_dina = 1'b0, update_BRAM_doutb = 1'b0, swap_bank = 1'b0;
   csz_t CHANNEL_SIZE = '0;
   logic last_loading_1ker, last_channel, load_busy, wbank_full, rbank_valid, tlast_err;
   kernel_bram_pingpong_cu_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
   kernel_bram_pingpong_cu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .Reset(Reset), .load_BRAM_dina(load_BRAM_dina),
      .update_BRAM_doutb(update_BRAM_doutb), .swap_bank(swap_bank),
      .CHANNEL_SIZE(CHANNEL_SIZE), .bus(bus),
      .last_loading_1ker(last_loading_1ker), .last_channel(last_channel),
      .load_busy(load_busy), .wbank_full(wbank_full), .rbank_valid(rbank_valid),
      .tlast_err(tlast_err)
   );
   always #5 clk = ~clk;
   int total = 0, bad = 0;
   logic [DATA_W-1:0] mem [2*DEPTH];
   always @(posedge clk) if (bus.wea_ker_BRAM) mem[bus.addra_ker_BRAM] <= bus.dina_ker_BRAM;
   // reference model: a load is "beats still owed", reads are an offset modulo the set size
   int m_left, m_beat, m_wsize, m_rsize, m_roff, m_wbank;
   bit m_done, m_full, m_valid, m_lc, m_err;
   logic [DATA_W-1:0] m_wdata [DEPTH];
   logic [DATA_W-1:0] m_rdata [DEPTH];
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      m_left = 0; m_beat = 0; m_wsize = 0; m_rsize = 0; m_roff = 0; m_wbank = 0;
      m_done = 0; m_full = 0; m_valid = 0; m_lc = 0; m_err = 0;
   endtask
   task automatic chk_zero();
      chk("rst_tready", bus.s_axis_tready, 0);
      chk("rst_ena", bus.ena_ker_BRAM, 0);
      chk("rst_wea", bus.wea_ker_BRAM, 0);
      chk("rst_addra", bus.addra_ker_BRAM, 0);
      chk("rst_enb", bus.enb_ker_BRAM, 0);
      chk("rst_addrb", bus.addrb_ker_BRAM, 0);
      chk("rst_last_ld", last_loading_1ker, 0);
      chk("rst_lastch", last_channel, 0);
      chk("rst_busy", load_busy, 0);
      chk("rst_wfull", wbank_full, 0);
      chk("rst_rvalid", rbank_valid, 0);
      chk("rst_terr", tlast_err, 0);
   endtask
   task automatic cyc();
      bit tr, hs, fin, idle, sw, ld;
      @(negedge clk);
      tr  = m_left > 0;
      hs  = tr && bus.s_axis_tvalid;
      fin = hs && m_left == 1;
      chk("tready", bus.s_axis_tready, tr);
      chk("ena", bus.ena_ker_BRAM, tr);
      chk("wea", bus.wea_ker_BRAM, hs);
      chk("addra", bus.addra_ker_BRAM, m_wbank * DEPTH + m_beat);
      chk("dina", bus.dina_ker_BRAM, bus.s_axis_tdata);
      chk("last_ld", last_loading_1ker, fin);
      chk("busy", load_busy, tr || m_done);
      chk("wfull", wbank_full, m_full);
      chk("rvalid", rbank_valid, m_valid);
      chk("enb", bus.enb_ker_BRAM, m_valid);
      chk("terr", tlast_err, m_err);
      chk("lastch", last_channel, m_lc);
      chk("addrb", bus.addrb_ker_BRAM, m_valid ? (1 - m_wbank) * DEPTH + m_roff : 0);
      if (m_valid) chk("rdata", mem[bus.addrb_ker_BRAM], m_rdata[m_roff]);
      idle = !tr && !m_done;
      sw   = swap_bank && idle && m_full;
      ld   = load_BRAM_dina && idle && !m_full && !sw && CHANNEL_SIZE != 0;
      m_done = 0;
      if (hs) begin
         m_wdata[m_beat] = bus.s_axis_tdata;
         if (bus.s_axis_tlast != fin) m_err = 1;
         m_beat++;
         m_left--;
         if (fin) begin
            m_done = 1;
            m_full = 1;
            m_beat = 0;
         end
      end
      if (ld) begin
         m_left  = int'(CHANNEL_SIZE);
         m_beat  = 0;
         m_wsize = int'(CHANNEL_SIZE);
      end
      if (sw) begin
         m_wbank = 1 - m_wbank;
         m_rsize = m_wsize;
         m_roff  = 0;
         m_full  = 0;
         m_valid = 1;
         m_lc    = 0;
         m_rdata = m_wdata;
      end else begin
         m_lc = 0;
         if (update_BRAM_doutb && m_valid) begin
            m_roff = (m_roff + 1) % m_rsize;
            m_lc   = m_roff == 0;
         end
      end
      @(posedge clk);
      #1;
      load_BRAM_dina = 0;
      update_BRAM_doutb = 0;
      swap_bank = 0;
   endtask
   task automatic pulse(input bit ld, input bit sw, input bit up, input int size);
      load_BRAM_dina = ld;
      swap_bank = sw;
      update_BRAM_doutb = up;
      CHANNEL_SIZE = csz_t'(size);
      cyc();
   endtask
   // stream the owed beats; gaps randomise tvalid, bad_last>=0 puts tlast on that beat index
   task automatic feed(input bit gaps, input int bad_last, input bit upd, input logic [DATA_W-1:0] base);
      int g = 0;
      int k = 0;
      while (m_left > 0 && g < 4000) begin
         bus.s_axis_tvalid = !gaps || ($urandom % 2 == 0);
         bus.s_axis_tdata  = base + DATA_W'(k);
         bus.s_axis_tlast  = bad_last >= 0 ? (k == bad_last) : (m_left == 1);
         update_BRAM_doutb = upd;
         if (bus.s_axis_tvalid) k++;
         cyc();
         g++;
      end
      chk("feed_bound", m_left, 0);
      bus.s_axis_tvalid = 0;
      bus.s_axis_tlast = 0;
   endtask
   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      bus.s_axis_tdata = '0;
      bus.s_axis_tvalid = 0;
      bus.s_axis_tlast = 0;
      model_reset();
      #2 Reset = 0;
      #1 chk_zero();
      @(negedge clk) Reset = 1;
      @(posedge clk) #1;
      pulse(0, 0, 1, 0);
      pulse(0, 1, 0, 0);
      pulse(1, 0, 0, 4);
      feed(0, -1, 0, 32'hA0);
      chk("basic_full", wbank_full, 1);
      pulse(0, 0, 0, 0);
      pulse(0, 1, 0, 0);
      for (int i = 0; i < 4; i++) pulse(0, 0, 1, 0);
      pulse(0, 0, 0, 0);
      pulse(1, 0, 1, 3);
      feed(1, -1, 1, 32'hB0);
      for (int i = 0; i < 3; i++) pulse(0, 0, 1, 0);
      pulse(0, 1, 0, 0);
      pulse(1, 0, 0, 4);
      feed(0, 1, 0, 32'hC0);
      chk("mismatch_err", tlast_err, 1);
      pulse(0, 0, 0, 0);
      pulse(1, 0, 0, 2);
      pulse(0, 1, 0, 0);
      pulse(0, 1, 0, 0);
      pulse(1, 0, 0, 5);
      for (int k = 0; k < 2; k++) begin
         bus.s_axis_tvalid = 1;
         bus.s_axis_tdata = 32'hD0 + DATA_W'(k);
         bus.s_axis_tlast = 0;
         cyc();
      end
      #2 Reset = 0;
      #1 chk_zero();
      model_reset();
      bus.s_axis_tvalid = 0;
      @(negedge clk) Reset = 1;
      @(posedge clk) #1;
      pulse(1, 0, 0, 3);
      feed(0, -1, 0, 32'hE0);
      pulse(0, 0, 0, 0);
      pulse(0, 1, 0, 0);
      pulse(1, 0, 1, DEPTH);
      feed(1, -1, 1, 32'h1000);
      pulse(0, 0, 0, 0);
      pulse(0, 1, 0, 0);
      for (int i = 0; i < DEPTH + 3; i++) pulse(0, 0, 1, 0);
      for (int i = 0; i < 3000; i++) begin
         load_BRAM_dina = ($urandom % 4) == 0;
         CHANNEL_SIZE = csz_t'($urandom_range(0, 6));
         swap_bank = ($urandom % 6) == 0;
         update_BRAM_doutb = ($urandom % 2) == 0;
         bus.s_axis_tvalid = ($urandom % 4) != 0;
         bus.s_axis_tdata = $urandom;
         bus.s_axis_tlast = (m_left == 1) ^ (($urandom % 25) == 0);
         cyc();
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
